ptn_reader: RTL and testbench
=============================

Name: ptn_reader

Overview:
- Read-side sequencer for the pattern RAM; the loader owns the write side.
- On start, fetches 16-bit pattern words from start_addr to end_addr inclusive, repeats the span loop_cnt times, and streams the words to the pattern executor over a valid/ready interface.
- Prefetches through a small FIFO so the executor sees back-to-back words despite the RAM's one-cycle read latency.

Parameters:
- ADDR_W, 24, pattern RAM address width.
- DATA_W, 16, pattern word width.
- FIFO_DEPTH, 4, prefetch FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins playback; ignored unless IDLE.
- abort  input  1  one-cycle pulse; stops playback and flushes the FIFO.
- start_addr  input  ADDR_W  first word address; sampled on start.
- end_addr  input  ADDR_W  last word address, inclusive; sampled on start.
- loop_cnt  input  16  number of passes over the span; 0 is treated as 1; sampled on start.
- ram_en  output  1  RAM enable; this block only reads, RAM we is tied low on this side.
- ram_addr  output  ADDR_W  RAM read address.
- ram_data  input  DATA_W  RAM read data; valid the cycle after ram_en.
- word_o  output  DATA_W  pattern word to executor.
- word_valid  output  1  word_o valid.
- word_ready  input  1  executor accepts word_o.
- busy  output  1  high from the cycle after start until done or abort.
- done  output  1  one-cycle pulse after the last word of the last pass is accepted.
- err_range  output  1  one-cycle pulse when start arrives with end_addr < start_addr.

Behaviour:
- Reset: all outputs 0, FIFO empty, state IDLE, counters 0.
- States:
  - IDLE: on start with end_addr >= start_addr, latch cur_addr=start_addr, end, passes_left=max(loop_cnt,1), then go to FETCH. If end_addr < start_addr, pulse err_range and stay in IDLE.
  - FETCH: issue reads while not finished.
  - DRAIN: all reads issued; wait for the FIFO to empty and the in-flight read to land.
  - DONE: pulse done for one cycle, then return to IDLE.
- Read issue:
  - Assert ram_en with ram_addr=cur_addr only when fifo_count + inflight < FIFO_DEPTH, where inflight is 0 or 1.
  - The read returns in the next cycle; ram_data is pushed into the FIFO that same cycle (RAM latency is exactly 1).
  - At most one read per cycle; sustained throughput is 1 word per cycle when word_ready is held high.
- Address sequencing:
  - After a read at end_addr: if passes_left > 1, decrement passes_left and reload cur_addr=start_addr (the wrap costs no bubble); otherwise go to DRAIN.
  - Otherwise cur_addr increments by 1.
  - Address arithmetic is ADDR_W wide with no wrap beyond end_addr.
- FIFO and handshake:
  - word_valid = FIFO non-empty; word_o = FIFO head (first-word fall-through).
  - Pop on word_valid & word_ready.
  - Push and pop in the same cycle leave the count unchanged.
  - word_o is held stable while word_valid=1 and word_ready=0.
- Latency: start at cycle T, ram_en at T+1, word_valid at T+2 with word_o = RAM[start_addr].
- Single-word span: start_addr == end_addr is legal and produces loop_cnt copies of that word.
- Abort: in any non-IDLE state, abort returns the block to IDLE next cycle, deasserts ram_en, empties the FIFO, drops any in-flight data, and does not pulse done. Abort and start in the same cycle: abort wins, start is ignored.
- start while busy: ignored.
- Reset mid-operation: immediate return to reset values; no partial done.

Test Plan:
- Preload RAM[0x10..0x13]=0xA000..0xA003; start_addr=0x10, end_addr=0x13, loop_cnt=1, ready held 1 -> words A000,A001,A002,A003 on 4 consecutive cycles; first word_valid 2 cycles after start; done 1 cycle after the last accept; busy falls with done.
- Same span, loop_cnt=3, ready=1 -> 12 words, sequence repeats with no bubble at the wrap; exactly one done pulse.
- Same span with word_ready toggling 1,0,0,1,... -> no word lost or duplicated; word_o stable while stalled; ram_en never asserted when FIFO count + inflight = 4.
- start_addr=0x20, end_addr=0x1F -> err_range pulse; busy stays 0; no ram_en.
- start_addr=end_addr=0x05 (RAM=0xBEEF), loop_cnt=0 -> exactly one 0xBEEF, then done.
- Abort after 2 words accepted, ready=0 -> next cycle: word_valid=0, ram_en=0, busy=0, no done; a subsequent start replays correctly from start_addr.

Source files
------------

// File: rtl/ptn_reader.sv
// Pattern RAM read sequencer: walks [start_addr..end_addr] loop_cnt times and streams
// words to the executor through a fall-through prefetch FIFO that hides the RAM read latency.
module ptn_reader #(
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic [15:0]       loop_cnt,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_data,
    output logic [DATA_W-1:0] word_o,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              busy,
    output logic              done,
    output logic              err_range
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_W-1:0] start_q, end_q;
    logic [15:0]       passes_q, passes_d;
    logic              load;
    logic              range_err;

    // Read stage: vld_p1 marks a read issued last cycle whose data is on ram_data now
    logic              vld_p1;
    logic              issue;
    logic [CNT_W-1:0]  occupancy;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  fifo_cnt, cnt_next;
    logic              fifo_empty;
    logic              fifo_push, fifo_pop;
    logic              accept;
    logic              flush;

    assign flush      = abort && (state_q != S_IDLE);
    assign occupancy  = fifo_cnt + CNT_W'(vld_p1);
    assign issue      = (state_q == S_FETCH) && !abort && (occupancy < CNT_W'(FIFO_DEPTH));

    // An empty FIFO passes the landing read straight through so the first word costs no extra cycle
    assign fifo_empty = (fifo_cnt == '0);
    assign word_valid = !fifo_empty || vld_p1;
    assign word_o     = fifo_empty ? ram_data : fifo_mem[rd_ptr];
    assign accept     = word_valid && word_ready;
    assign fifo_pop   = accept && !fifo_empty;
    assign fifo_push  = vld_p1 && !(fifo_empty && word_ready);
    assign cnt_next   = fifo_cnt + CNT_W'(fifo_push) - CNT_W'(fifo_pop);

    assign ram_en     = issue;
    assign ram_addr   = cur_addr_q;
    assign busy       = (state_q == S_FETCH) || (state_q == S_DRAIN);
    assign done       = (state_q == S_DONE);

    assign range_err  = (state_q == S_IDLE) && start && !abort && (end_addr < start_addr);

    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        passes_d   = passes_q;
        load       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !abort && (end_addr >= start_addr)) begin
                    state_d    = S_FETCH;
                    cur_addr_d = start_addr;
                    passes_d   = (loop_cnt == 16'd0) ? 16'd1 : loop_cnt;
                    load       = 1'b1;
                end
            end
            S_FETCH: begin
                if (issue) begin
                    if (cur_addr_q == end_q) begin
                        // Wrap reloads the address in the same cycle as the last read of the pass
                        if (passes_q > 16'd1) begin
                            passes_d   = passes_q - 16'd1;
                            cur_addr_d = start_q;
                        end else begin
                            state_d = S_DRAIN;
                        end
                    end else begin
                        cur_addr_d = cur_addr_q + ADDR_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (cnt_next == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (flush) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cur_addr_q <= '0;
            start_q    <= '0;
            end_q      <= '0;
            passes_q   <= '0;
            err_range  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            passes_q   <= passes_d;
            err_range  <= range_err;
            if (load) begin
                start_q <= start_addr;
                end_q   <= end_addr;
            end
        end
    end

    // FIFO control and read-stage valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (flush) begin
            vld_p1   <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            vld_p1   <= issue;
            fifo_cnt <= cnt_next;
            if (fifo_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr] <= ram_data;
        end
    end

endmodule

// File: tb/tb_ptn_reader.sv
// Bench for ptn_reader: table-driven playback scenarios, hand-written abort/reset/restart
// sequences and randomized runs, all scored against a word-list model built from the span rules.
module tb_ptn_reader;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [23:0] start_addr = '0;
    logic [23:0] end_addr = '0;
    logic [15:0] loop_cnt = '0;
    logic        ram_en;
    logic [23:0] ram_addr;
    logic [15:0] ram_data;
    logic [15:0] word_o;
    logic        word_valid;
    logic        word_ready = 1'b0;
    logic        busy;
    logic        done;
    logic        err_range;

    ptn_reader #(.ADDR_W(24), .DATA_W(16), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .start_addr(start_addr), .end_addr(end_addr), .loop_cnt(loop_cnt),
        .ram_en(ram_en), .ram_addr(ram_addr), .ram_data(ram_data),
        .word_o(word_o), .word_valid(word_valid), .word_ready(word_ready),
        .busy(busy), .done(done), .err_range(err_range)
    );

    always #5 clk = ~clk;

    // Pattern RAM fixture with one-cycle read latency
    logic [15:0] mem [0:255];
    logic [15:0] ram_q = '0;
    always @(posedge clk) if (ram_en) ram_q <= mem[ram_addr[7:0]];
    assign ram_data = ram_q;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    logic [15:0] exp_q [$];
    int acc_cnt, done_cnt, err_cnt, en_cnt, outstanding;
    int first_valid_cyc, first_acc_cyc, last_acc_cyc, done_cyc, start_cyc;
    bit prev_stall = 1'b0;
    logic [15:0] prev_word;

    task automatic clear_stats();
        acc_cnt = 0; done_cnt = 0; err_cnt = 0; en_cnt = 0;
        first_valid_cyc = -1; first_acc_cyc = -1; last_acc_cyc = -1; done_cyc = -1;
    endtask

    // Monitor: scoreboard, stall stability, occupancy bound, done/err bookkeeping
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall  = 1'b0;
            outstanding = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", word_valid, 1);
                chk("stall_word", word_o, prev_word);
            end
            if (word_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (ram_en) begin
                chk("occupancy_below_depth", outstanding < DEPTH, 1);
                en_cnt++;
            end
            if (word_valid && word_ready) begin
                acc_cnt++;
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
                last_acc_cyc = cyc;
                chk("word_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) chk("word_value", word_o, exp_q.pop_front());
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("busy_low_at_done", busy, 0);
            end
            if (err_range) err_cnt++;
            outstanding = outstanding + int'(ram_en) - int'(word_valid && word_ready);
            if (abort) outstanding = 0;
            prev_stall = word_valid && !word_ready && !abort;
            prev_word  = word_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic ready_fn(input int mode, input int i);
        case (mode)
            0: return 1'b1;
            1: return (i % 3) == 0;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    typedef struct {
        logic [23:0] sa;
        logic [23:0] ea;
        logic [15:0] lp;
        int          mode;
        int          restart_at;
        int          exp_n;
        bit          exp_err;
        int          exp_done;
    } vec_t;

    // Expected word stream straight from the span/pass rules
    task automatic build_expect(input vec_t v);
        int passes;
        exp_q.delete();
        passes = (v.lp == 0) ? 1 : int'(v.lp);
        if (v.ea >= v.sa)
            for (int p = 0; p < passes; p++)
                for (int a = int'(v.sa); a <= int'(v.ea); a++)
                    exp_q.push_back(mem[a[7:0]]);
    endtask

    task automatic run_play(input vec_t v);
        int i, lim;
        build_expect(v);
        clear_stats();
        start_addr = v.sa; end_addr = v.ea; loop_cnt = v.lp;
        start = 1'b1;
        word_ready = ready_fn(v.mode, 0);
        start_cyc = cyc;
        tick();
        start = 1'b0;
        word_ready = ready_fn(v.mode, 1);
        chk("busy_after_start", busy, !v.exp_err);
        chk("err_range_pulse", err_range, v.exp_err);
        chk("ram_en_after_start", ram_en, !v.exp_err);
        lim = v.exp_err ? 10 : 400;
        i = 2;
        while (done_cnt == 0 && i < lim) begin
            tick();
            word_ready = ready_fn(v.mode, i);
            if (i == v.restart_at) begin
                start = 1'b1; start_addr = 24'h30; end_addr = 24'h31; loop_cnt = 16'd1;
            end else begin
                start = 1'b0;
            end
            i++;
        end
        start = 1'b0;
        word_ready = 1'b0;
        repeat (4) tick();
        chk("words_accepted", acc_cnt, v.exp_n);
        chk("words_left", exp_q.size(), 0);
        chk("done_pulses", done_cnt, v.exp_done);
        chk("err_pulses", err_cnt, int'(v.exp_err));
        chk("reads_issued", en_cnt, v.exp_n);
        chk("busy_idle_after", busy, 0);
        if (v.exp_n > 0) begin
            chk("first_valid_latency", first_valid_cyc - start_cyc, 2);
            chk("done_after_last_accept", done_cyc, last_acc_cyc + 1);
            if (v.mode == 0) chk("back_to_back_span", last_acc_cyc - first_acc_cyc + 1, v.exp_n);
        end else begin
            chk("no_valid_on_err", first_valid_cyc, -1);
        end
    endtask

    vec_t tbl [7];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        for (int a = 0; a < 256; a++) mem[a] = 16'hC000 + 16'(a);
        for (int a = 0; a < 4; a++) mem[16 + a] = 16'hA000 + 16'(a);
        mem[5] = 16'hBEEF;

        //            sa      ea      lp    mode restart n   err  done
        tbl[0] = '{24'h10, 24'h13, 16'd1, 0, -1, 4,  1'b0, 1};
        tbl[1] = '{24'h10, 24'h13, 16'd3, 0, -1, 12, 1'b0, 1};
        tbl[2] = '{24'h10, 24'h13, 16'd1, 1, -1, 4,  1'b0, 1};
        tbl[3] = '{24'h20, 24'h1F, 16'd1, 0, -1, 0,  1'b1, 0};
        tbl[4] = '{24'h05, 24'h05, 16'd0, 0, -1, 1,  1'b0, 1};
        tbl[5] = '{24'h05, 24'h05, 16'd3, 1, -1, 3,  1'b0, 1};
        tbl[6] = '{24'h10, 24'h13, 16'd2, 0, 4,  8,  1'b0, 1};

        // Reset state
        #3;
        chk("rst_ram_en", ram_en, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_word_valid", word_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err_range", err_range, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        for (int k = 0; k < 7; k++) run_play(tbl[k]);

        // Abort after two words with the executor stalled
        v = tbl[0];
        build_expect(v);
        clear_stats();
        start_addr = v.sa; end_addr = v.ea; loop_cnt = v.lp;
        start = 1'b1; word_ready = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        word_ready = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_word_valid", word_valid, 0);
        chk("abort_ram_en", ram_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        repeat (5) tick();
        chk("abort_accepted", acc_cnt, 2);
        chk("abort_no_done", done_cnt, 0);
        exp_q.delete();
        run_play(tbl[0]);

        // Abort and start together in IDLE: start is ignored
        clear_stats();
        start_addr = 24'h10; end_addr = 24'h13; loop_cnt = 16'd1;
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("abort_start_busy", busy, 0);
        repeat (4) tick();
        chk("abort_start_reads", en_cnt, 0);

        // Reset in the middle of a run
        v = tbl[1];
        build_expect(v);
        clear_stats();
        start_addr = v.sa; end_addr = v.ea; loop_cnt = v.lp;
        start = 1'b1; word_ready = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_ram_en", ram_en, 0);
        chk("midrst_word_valid", word_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ram_addr", ram_addr, 0);
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        chk("midrst_no_done", done_cnt, 0);
        exp_q.delete();
        word_ready = 1'b0;

        // Randomized runs
        for (int r = 0; r < 24; r++) begin
            v.sa = 24'($urandom_range(1, 63));
            if ($urandom_range(0, 5) == 0) v.ea = v.sa - 24'd1;
            else v.ea = v.sa + 24'($urandom_range(0, 7));
            v.lp = 16'($urandom_range(0, 3));
            v.mode = $urandom_range(0, 2);
            v.exp_err = (v.ea < v.sa);
            v.restart_at = (!v.exp_err && $urandom_range(0, 1) == 1) ? 3 : -1;
            v.exp_n = v.exp_err ? 0 : int'(v.ea - v.sa + 24'd1) * ((v.lp == 0) ? 1 : int'(v.lp));
            v.exp_done = v.exp_err ? 0 : 1;
            run_play(v);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
